// File: rtl/field_packer_pkg.sv
// Shared definitions for the field packer.
//   NFIELDS_DEF / FW_DEF : default field count and field width
//   state_t              : pass control states
//   idx_width()          : width of the field index counter
package field_packer_pkg;

  localparam int NFIELDS_DEF = 8;
  localparam int FW_DEF      = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-field packer still needs a 1-bit index so the port stays legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/field_packer_field_gen.sv
// Combinational field generator: field = (idx << (idx + shamt)) truncated to FW.
//   idx   : field index
//   shamt : extra left shift latched for the pass
//   field : low FW bits of the shifted index
module field_gen #(
  parameter int NFIELDS = 8,
  parameter int FW      = 10,
  parameter int IW      = 3
) (
  input  logic [IW-1:0] idx,
  input  logic [1:0]    shamt,
  output logic [FW-1:0] field
);

  // Wide enough that the largest shift never loses bits before truncation.
  localparam int SW = FW + NFIELDS + 3;
  // Holds idx + shamt, whose maximum is NFIELDS-1+3.
  localparam int AW = IW + 2;

  logic [SW-1:0] ext;
  logic [AW-1:0] amt;

  assign ext   = SW'(idx);
  assign amt   = AW'(idx) + AW'(shamt);
  assign field = FW'(ext << amt);

endmodule

// File: rtl/field_packer.sv
// Field packer: on an accepted start, writes NFIELDS generated fields into a
// packed word, one per cycle, field 0 in the MSBs, then presents the word with
// a valid/ready handshake.
//   clk       : clock, all state on posedge
//   reset_l   : asynchronous active-low reset
//   start     : begin a pass (only honoured in IDLE)
//   shamt     : extra left shift, latched with start
//   busy      : high while a pass is running or waiting for acceptance
//   out_valid : packed word available
//   out_ready : consumer accepts the word together with out_valid
//   out_data  : packed word
module field_packer #(
  parameter int NFIELDS = field_packer_pkg::NFIELDS_DEF,
  parameter int FW      = field_packer_pkg::FW_DEF
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  start,
  input  logic [1:0]            shamt,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NFIELDS*FW-1:0] out_data
);

  import field_packer_pkg::*;

  localparam int IW = idx_width(NFIELDS);
  localparam logic [IW-1:0] LAST = IW'(NFIELDS - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] i_q;
  logic [1:0]    shamt_q;
  logic [FW-1:0] field;

  field_gen #(
    .NFIELDS (NFIELDS),
    .FW      (FW),
    .IW      (IW)
  ) u_field_gen (
    .idx   (i_q),
    .shamt (shamt_q),
    .field (field)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)        state_d = RUN;
      RUN:     if (i_q == LAST)  state_d = DONE;
      DONE:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      i_q      <= '0;
      shamt_q  <= '0;
      out_data <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shamt_q  <= shamt;
            i_q      <= '0;
            out_data <= '0;
          end
        end
        RUN: begin
          out_data[NFIELDS*FW-1-FW*int'(i_q) -: FW] <= field;
          // Park on the last index rather than wrapping; the next start clears it.
          if (i_q != LAST) i_q <= i_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_field_packer.sv
module tb_field_packer;

  localparam logic [79:0] EXP0 = 80'h0000202018100a060380;
  localparam logic [79:0] EXP1 = 80'h000040403020140c0300;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        start;
  logic [1:0]  shamt;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] out_data;

  int vectors     = 0;
  int miscompares = 0;

  field_packer dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .start     (start),
    .shamt     (shamt),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete pass: start, 8 RUN cycles, optional ready-low hold in DONE,
  // handshake. With disturb set, start/shamt/out_ready are wiggled during RUN
  // and start is raised together with the handshake.
  task automatic run_pass(input logic [1:0] sh, input logic [79:0] exp,
                          input int hold, input bit disturb);
    logic [2:0] k3;
    start = 1'b1;
    shamt = sh;
    step();
    start = 1'b0;
    check("run_busy", 80'(busy), 80'd1);
    check("run_cleared", out_data, 80'd0);
    for (int k = 1; k < 8; k++) begin
      if (disturb) begin
        k3        = 3'(k);
        start     = k3[0];
        shamt     = ~sh ^ k3[1:0];
        out_ready = k3[1];
      end
      step();
      check($sformatf("run_novalid_%0d", k), 80'(out_valid), 80'd0);
    end
    start     = 1'b0;
    out_ready = disturb;
    step();
    out_ready = 1'b0;
    check("done_valid", 80'(out_valid), 80'd1);
    check("done_busy", 80'(busy), 80'd1);
    check("done_data", out_data, exp);
    for (int h = 0; h < hold; h++) begin
      start = disturb;
      step();
      check($sformatf("hold_valid_%0d", h), 80'(out_valid), 80'd1);
      check($sformatf("hold_data_%0d", h), out_data, exp);
    end
    out_ready = 1'b1;
    start     = disturb;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    shamt     = sh;
    check("hs_busy", 80'(busy), 80'd0);
    check("hs_valid", 80'(out_valid), 80'd0);
    check("hs_data_kept", out_data, exp);
    if (disturb) begin
      step();
      check("no_restart_busy", 80'(busy), 80'd0);
      check("no_restart_data", out_data, exp);
    end
  endtask

  initial begin
    reset_l   = 1'b0;
    start     = 1'b0;
    shamt     = 2'd0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_valid", 80'(out_valid), 80'd0);
    check("rst_data", out_data, 80'd0);
    reset_l = 1'b1;
    step();

    // Basic pass, shamt 0
    run_pass(2'd0, EXP0, 0, 1'b0);
    // shamt 1 with field 7 truncation, ready held low 5 cycles
    run_pass(2'd1, EXP1, 5, 1'b0);
    // Start / shamt / ready noise mid-pass and start at the handshake
    run_pass(2'd0, EXP0, 0, 1'b1);

    // Reset at the 4th RUN cycle
    start = 1'b1;
    shamt = 2'd1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("midrun_busy", 80'(busy), 80'd1);
    reset_l = 1'b0;
    #1;
    check("async_rst_busy", 80'(busy), 80'd0);
    check("async_rst_valid", 80'(out_valid), 80'd0);
    check("async_rst_data", out_data, 80'd0);
    step();
    reset_l = 1'b1;
    step();
    check("post_rst_idle", 80'(busy), 80'd0);
    check("post_rst_valid", 80'(out_valid), 80'd0);
    run_pass(2'd0, EXP0, 0, 1'b0);

    // Back-to-back passes, no idle gap
    run_pass(2'd0, EXP0, 0, 1'b0);
    run_pass(2'd1, EXP1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
